unit_vector_sequencer: RTL



---
 rtl/unit_vector_sequencer.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/unit_vector_sequencer.sv
// -----------------------------------------------------------------------------
// unit_vector_sequencer
//
// On-chip stimulus/response checker for up to NUM_CH datapath units. Vectors
// (operands, control, expected result) are loaded per channel while idle. On
// start, every non-empty channel is walked in ascending channel/index order:
// each vector is presented over a valid/ready handshake, the unit's response is
// compared against the expected value, and pass/fail totals, the first mismatch
// and a sticky timeout flag are reported.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   start                       begin a run (idle only, ignored while ld_en)
//   ld_en, ld_ch, ld_idx        write one vector slot (idle only)
//   ld_a, ld_b, ld_ctl, ld_exp  vector contents
//   ld_last                     with ld_en: channel length becomes ld_idx+1
//   dut_valid/dut_ready         vector handshake towards the unit under test
//   dut_ch, dut_a, dut_b, dut_ctl  presented vector
//   rsp_valid, rsp_data         unit response, sampled only while waiting
//   busy, done                  run in progress / one-cycle end-of-run pulse
//   pass_count, fail_count      run totals
//   first_fail_ch/idx/data      location and data of the first mismatch
//   timeout_seen                sticky: some vector got no response in time
// -----------------------------------------------------------------------------
module unit_vector_sequencer #(
    parameter int WIDTH   = 32,
    parameter int NUM_CH  = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15,
    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IDXW = $clog2(DEPTH),
    localparam int CNTW = CHW + IDXW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ld_en,
    input  logic [CHW-1:0]   ld_ch,
    input  logic [IDXW-1:0]  ld_idx,
    input  logic [WIDTH-1:0] ld_a,
    input  logic [WIDTH-1:0] ld_b,
    input  logic [3:0]       ld_ctl,
    input  logic [WIDTH-1:0] ld_exp,
    input  logic             ld_last,
    output logic             dut_valid,
    output logic [CHW-1:0]   dut_ch,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    output logic [3:0]       dut_ctl,
    input  logic             dut_ready,
    input  logic             rsp_valid,
    input  logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  pass_count,
    output logic [CNTW-1:0]  fail_count,
    output logic [CHW-1:0]   first_fail_ch,
    output logic [IDXW-1:0]  first_fail_idx,
    output logic [WIDTH-1:0] first_fail_data,
    output logic             timeout_seen
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int VW  = 3 * WIDTH + 4;

    // Vector word layout: {a, b, ctl, expected}
    logic [VW-1:0]    mem_r [NUM_CH][DEPTH];
    logic [IDXW:0]    ch_len_r [NUM_CH];

    logic [2:0]       state_r;
    logic [2:0]       state_next_s;
    logic [CHW-1:0]   cur_ch_r;
    logic [IDXW-1:0]  cur_idx_r;
    logic [WCW-1:0]   wait_cnt_r;
    logic [WIDTH-1:0] exp_r;

    logic             first_found_s;
    logic [CHW-1:0]   first_ch_s;
    logic             next_found_s;
    logic [CHW-1:0]   next_ch_s;
    logic [IDXW:0]    idx_inc_s;
    logic [IDXW:0]    ld_len_s;
    logic             more_s;
    logic             outcome_s;
    logic             pass_s;
    logic             tmo_s;

    // Channel search: lowest non-empty channel, and lowest non-empty above cur_ch.
    // The loop runs downward so the lowest matching channel is the last writer.
    always_comb begin
        first_found_s = 1'b0;
        first_ch_s    = '0;
        next_found_s  = 1'b0;
        next_ch_s     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            first_found_s = first_found_s | (ch_len_r[i] != '0);
            first_ch_s    = (ch_len_r[i] != '0) ? CHW'(i) : first_ch_s;
            next_found_s  = next_found_s | ((ch_len_r[i] != '0) && (CHW'(i) > cur_ch_r));
            next_ch_s     = ((ch_len_r[i] != '0) && (CHW'(i) > cur_ch_r)) ? CHW'(i) : next_ch_s;
        end
    end

    // Index arithmetic for the advance decision and for channel length loads.
    always_comb begin
        idx_inc_s = {1'b0, cur_idx_r} + (IDXW + 1)'(1);
        ld_len_s  = {1'b0, ld_idx} + (IDXW + 1)'(1);
        more_s    = (idx_inc_s < ch_len_r[cur_ch_r]);
    end

    // Next-state logic and the per-vector outcome while waiting for a response.
    always_comb begin
        state_next_s = state_r;
        outcome_s    = 1'b0;
        pass_s       = 1'b0;
        tmo_s        = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && !ld_en) begin
                    state_next_s = first_found_s ? S_FETCH : S_DONE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                state_next_s = S_ISSUE;
            end
            S_ISSUE: begin
                if (dut_ready) begin
                    state_next_s = S_WAIT;
                end else begin
                    state_next_s = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    outcome_s = 1'b1;
                    pass_s    = (rsp_data == exp_r);
                end else if (wait_cnt_r == WCW'(TIMEOUT - 1)) begin
                    outcome_s = 1'b1;
                    tmo_s     = 1'b1;
                end else begin
                    outcome_s = 1'b0;
                end
                if (!outcome_s) begin
                    state_next_s = S_WAIT;
                end else if (more_s || next_found_s) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Vector storage: written only while idle and never reset.
    always_ff @(posedge clk) begin
        if (!reset && (state_r == S_IDLE) && ld_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ld_ch == CHW'(i)) begin
                    mem_r[i][ld_idx] <= {ld_a, ld_b, ld_ctl, ld_exp};
                end
            end
        end
    end

    // Sequencer state, channel lengths, handshake outputs and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= S_IDLE;
            cur_ch_r        <= '0;
            cur_idx_r       <= '0;
            wait_cnt_r      <= '0;
            exp_r           <= '0;
            dut_valid       <= 1'b0;
            dut_ch          <= '0;
            dut_a           <= '0;
            dut_b           <= '0;
            dut_ctl         <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass_count      <= '0;
            fail_count      <= '0;
            first_fail_ch   <= '0;
            first_fail_idx  <= '0;
            first_fail_data <= '0;
            timeout_seen    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_len_r[i] <= '0;
            end
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s == S_FETCH) || (state_next_s == S_ISSUE) ||
                       (state_next_s == S_WAIT);
            done    <= (state_next_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (ld_en) begin
                        if (ld_last) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (ld_ch == CHW'(i)) begin
                                    ch_len_r[i] <= ld_len_s;
                                end
                            end
                        end
                    end else if (start) begin
                        pass_count      <= '0;
                        fail_count      <= '0;
                        first_fail_ch   <= '0;
                        first_fail_idx  <= '0;
                        first_fail_data <= '0;
                        timeout_seen    <= 1'b0;
                        cur_ch_r        <= first_ch_s;
                        cur_idx_r       <= '0;
                    end
                end
                S_FETCH: begin
                    {dut_a, dut_b, dut_ctl, exp_r} <= mem_r[cur_ch_r][cur_idx_r];
                    dut_ch    <= cur_ch_r;
                    dut_valid <= 1'b1;
                end
                S_ISSUE: begin
                    if (dut_ready) begin
                        dut_valid  <= 1'b0;
                        wait_cnt_r <= '0;
                    end
                end
                S_WAIT: begin
                    if (outcome_s) begin
                        if (pass_s) begin
                            pass_count <= pass_count + CNTW'(1);
                        end else begin
                            fail_count <= fail_count + CNTW'(1);
                            // Only the first failure of a run is recorded.
                            if (fail_count == '0) begin
                                first_fail_ch   <= cur_ch_r;
                                first_fail_idx  <= cur_idx_r;
                                first_fail_data <= tmo_s ? '0 : rsp_data;
                            end
                            if (tmo_s) begin
                                timeout_seen <= 1'b1;
                            end
                        end
                        if (more_s) begin
                            cur_idx_r <= idx_inc_s[IDXW-1:0];
                        end else if (next_found_s) begin
                            cur_ch_r  <= next_ch_s;
                            cur_idx_r <= '0;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WCW'(1);
                    end
                end
                S_DONE: begin
                    cur_idx_r <= '0;
                end
                default: begin
                    cur_idx_r <= '0;
                end
            endcase
        end
    end

endmodule
